debug_frame_tx: RTL and testbench

Serial transmitter for the debug link. On request it snapshots the seven 8-bit debug ports exported by the CPU top level and sends them to the host-side serial port debugger as a framed UART stream. The frame is a sync byte, the seven data bytes and an XOR checksum. The block sits between the `cpu` debug outputs and the board's UART TX pin, and is the transmit end of the protocol the host debugger receives.

---
 rtl/debug_frame_tx.sv | 168 ++++++++++++++++
 tb/tb_debug_frame_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_tx.sv
// Debug-link UART transmitter: snapshots seven debug bytes on start and sends
// SYNC, the seven bytes and an XOR checksum as one 8N1 frame.
module debug_frame_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [3:0]      byte_reg, byte_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            snap_load;

  logic [7:0]      port_bytes [7];
  logic [7:0]      snap_reg [7];
  logic [7:0]      chk_byte;
  logic [7:0]      cur_byte;
  logic            baud_last;

  assign port_bytes[0] = debug_port1;
  assign port_bytes[1] = debug_port2;
  assign port_bytes[2] = debug_port3;
  assign port_bytes[3] = debug_port4;
  assign port_bytes[4] = debug_port5;
  assign port_bytes[5] = debug_port6;
  assign port_bytes[6] = debug_port7;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 7; i++) snap_reg[i] <= 8'h00;
    end else if (snap_load) begin
      for (int i = 0; i < 7; i++) snap_reg[i] <= port_bytes[i];
    end
  end

  // Checksum comes from the snapshot, so port changes mid-frame never leak in.
  always_comb begin
    chk_byte = SYNC_BYTE;
    for (int i = 0; i < 7; i++) chk_byte = chk_byte ^ snap_reg[i];
  end

  always_comb begin
    cur_byte = chk_byte;
    if (byte_reg == 4'd0) cur_byte = SYNC_BYTE;
    for (int i = 0; i < 7; i++) begin
      if (byte_reg == 4'(i + 1)) cur_byte = snap_reg[i];
    end
  end

  assign baud_last = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= 3'd0;
      byte_reg  <= 4'd0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // tx is computed one step ahead so the line level is registered on the
  // same edge the state changes.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    snap_load  = 1'b0;
    case (state_reg)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          state_next = START;
          baud_next  = '0;
          bit_next   = 3'd0;
          byte_next  = 4'd0;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          snap_load  = 1'b1;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
          tx_next    = cur_byte[0];
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
            tx_next  = cur_byte[bit_reg + 3'd1];
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          if (byte_reg == 4'd8) begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            byte_next  = byte_reg + 4'd1;
            state_next = START;
            tx_next    = 1'b0;
          end
        end else begin
          baud_next = baud_reg + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx at 16 clocks per bit: decodes tx at
// mid-bit and checks frame contents, busy width, done pulses and resets.
module tb_debug_frame_tx;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] p [7];
  logic       tx, busy, done;

  int checks = 0;
  int errors = 0;

  logic       bits [90];
  logic [7:0] rx [9];
  int         busy_len, done_cnt;
  logic       framing_ok, first_tx, first_busy, end_tx;

  debug_frame_tx #(.CLKS_PER_BIT(16), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .nreset(nreset), .start(start),
    .debug_port1(p[0]), .debug_port2(p[1]), .debug_port3(p[2]),
    .debug_port4(p[3]), .debug_port5(p[4]), .debug_port6(p[5]),
    .debug_port7(p[6]),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Raise start for one edge; returns on the negedge after the accept edge (cycle 0).
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  // Follows one frame from cycle 0 until busy drops, sampling tx mid-bit.
  task automatic monitor_frame(input int ign_a, input int ign_b, input logic hold);
    busy_len = 0;
    done_cnt = 0;
    first_tx = tx;
    first_busy = busy;
    end_tx = 1'b0;
    for (int j = 0; j < 90; j++) bits[j] = 1'b0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if ((cyc % 16) == 8 && (cyc / 16) < 90) bits[cyc / 16] = tx;
      if (busy) busy_len++;
      if (done) done_cnt++;
      if (!busy) begin
        end_tx = tx;
        start = hold;
        break;
      end
      start = hold || (cyc == ign_a) || (cyc == ign_b);
    end
    framing_ok = 1'b1;
    for (int b = 0; b < 9; b++) begin
      for (int m = 0; m < 8; m++) rx[b][m] = bits[10 * b + 1 + m];
      if (bits[10 * b] !== 1'b0 || bits[10 * b + 9] !== 1'b1) framing_ok = 1'b0;
    end
    $display("frame: %h %h %h %h %h %h %h %h %h busy=%0d done=%0d",
             rx[0], rx[1], rx[2], rx[3], rx[4], rx[5], rx[6], rx[7], rx[8],
             busy_len, done_cnt);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = ~start;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
      end
    end
    @(negedge clk);
    start = 1'b0;
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_release got tx=%b busy=%b done=%b want 1 0 0", tx, busy, done);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [9];
    exp_b[0] = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      p[i] = 8'(i + 1);
      exp_b[i + 1] = 8'(i + 1);
    end
    exp_b[8] = 8'hA5;
    kick();
    monitor_frame(-1, -1, 1'b0);
    checks++;
    if (first_tx !== 1'b0 || first_busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency got tx=%b busy=%b want 0 1", first_tx, first_busy);
    end
    for (int b = 0; b < 9; b++) begin
      checks++;
      if (rx[b] !== exp_b[b]) begin
        errors++;
        $display("FAIL basic_byte%0d got %h want %h", b, rx[b], exp_b[b]);
      end
    end
    checks++;
    if (framing_ok !== 1'b1) begin
      errors++;
      $display("FAIL basic_framing got %b want 1", framing_ok);
    end
    checks++;
    if (busy_len != 1440) begin
      errors++;
      $display("FAIL basic_busy_len got %0d want 1440", busy_len);
    end
    checks++;
    if (done_cnt != 1 || end_tx !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got done=%0d tx=%b want 1 1", done_cnt, end_tx);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL basic_after got done=%b busy=%b tx=%b want 0 0 1", done, busy, tx);
    end
  endtask

  task automatic test_snapshot();
    for (int i = 0; i < 7; i++) p[i] = 8'hFF;
    kick();
    for (int i = 0; i < 7; i++) p[i] = 8'h00;
    monitor_frame(-1, -1, 1'b0);
    checks++;
    if (rx[0] !== 8'hA5) begin
      errors++;
      $display("FAIL snap_sync got %h want a5", rx[0]);
    end
    for (int b = 1; b < 8; b++) begin
      checks++;
      if (rx[b] !== 8'hFF) begin
        errors++;
        $display("FAIL snap_byte%0d got %h want ff", b, rx[b]);
      end
    end
    checks++;
    if (rx[8] !== 8'h5A) begin
      errors++;
      $display("FAIL snap_chk got %h want 5a", rx[8]);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start();
    int extra_busy;
    for (int i = 0; i < 7; i++) p[i] = 8'(i + 1);
    kick();
    monitor_frame(100, 700, 1'b0);
    checks++;
    if (busy_len != 1440 || done_cnt != 1) begin
      errors++;
      $display("FAIL ignored_len got busy=%0d done=%0d want 1440 1", busy_len, done_cnt);
    end
    checks++;
    if (rx[4] !== 8'h04 || rx[8] !== 8'hA5 || framing_ok !== 1'b1) begin
      errors++;
      $display("FAIL ignored_bytes got %h %h framing=%b want 04 a5 1", rx[4], rx[8], framing_ok);
    end
    extra_busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) extra_busy++;
    end
    checks++;
    if (extra_busy != 0) begin
      errors++;
      $display("FAIL ignored_queued got %0d busy cycles want 0", extra_busy);
    end
  endtask

  task automatic test_back_to_back();
    p[0] = 8'h3C;
    for (int i = 1; i < 6; i++) p[i] = 8'h00;
    p[6] = 8'h81;
    kick();
    monitor_frame(-1, -1, 1'b1);
    checks++;
    if (busy_len != 1440 || done_cnt != 1 || end_tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_frame1 got busy=%0d done=%0d gap_tx=%b want 1440 1 1",
               busy_len, done_cnt, end_tx);
    end
    checks++;
    if (rx[8] !== 8'h18 || framing_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_chk1 got %h framing=%b want 18 1", rx[8], framing_ok);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got tx=%b busy=%b want 0 1", tx, busy);
    end
    monitor_frame(-1, -1, 1'b0);
    checks++;
    if (busy_len != 1440 || done_cnt != 1) begin
      errors++;
      $display("FAIL b2b_frame2 got busy=%0d done=%0d want 1440 1", busy_len, done_cnt);
    end
    checks++;
    if (rx[0] !== 8'hA5 || rx[1] !== 8'h3C || rx[7] !== 8'h81 || rx[8] !== 8'h18) begin
      errors++;
      $display("FAIL b2b_bytes2 got %h %h %h %h want a5 3c 81 18", rx[0], rx[1], rx[7], rx[8]);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int bad_cnt;
    for (int i = 0; i < 7; i++) p[i] = 8'(i + 1);
    kick();
    start = 1'b0;
    // byte 4 bit 3 spans bit slot 44: cycles 704..719
    repeat (709) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got tx=%b busy=%b want 0 1", tx, busy);
    end
    #2 nreset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async got tx=%b busy=%b want 1 0", tx, busy);
    end
    bad_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad_cnt++;
    end
    checks++;
    if (bad_cnt != 0) begin
      errors++;
      $display("FAIL midrst_hold got %0d bad cycles want 0", bad_cnt);
    end
    start = 1'b0;
    nreset = 1'b1;
    @(negedge clk);
    p[0] = 8'h3C;
    for (int i = 1; i < 6; i++) p[i] = 8'h00;
    p[6] = 8'h81;
    kick();
    monitor_frame(-1, -1, 1'b0);
    checks++;
    if (rx[0] !== 8'hA5 || rx[1] !== 8'h3C || rx[2] !== 8'h00 || rx[7] !== 8'h81
        || rx[8] !== 8'h18 || framing_ok !== 1'b1) begin
      errors++;
      $display("FAIL midrst_frame got %h %h %h %h %h framing=%b want a5 3c 00 81 18 1",
               rx[0], rx[1], rx[2], rx[7], rx[8], framing_ok);
    end
    checks++;
    if (busy_len != 1440 || done_cnt != 1) begin
      errors++;
      $display("FAIL midrst_len got busy=%0d done=%0d want 1440 1", busy_len, done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 7; i++) p[i] = 8'h00;
    test_reset();
    test_basic();
    test_snapshot();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
